imem_loader: RTL

- Boot-time program loader; the write side of the instruction memory that the processor fetches from and decodes.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the core in reset until the whole image is loaded.

---
 rtl/imem_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream to little-endian words written into instruction memory
// Holds the core in reset until a header-announced image has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_wa,
  output logic [31:0]           imem_wd,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   loaded_words
);

  localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [15:0]         r_n;
  logic [1:0]          r_byte_cnt;
  logic [ADDR_WIDTH:0] r_word_cnt;
  logic [23:0]         r_word;

  logic                w_xfer;
  logic [15:0]         w_n_full;
  logic [ADDR_WIDTH:0] w_cnt_next;
  logic                w_last_word;
  logic                w_too_big;

  // in_ready is the only output not registered: it must drop in the same cycle reset rises.
  assign in_ready     = ~reset & ((r_state == S_HDR0) | (r_state == S_HDR1) | (r_state == S_DATA));
  assign w_xfer       = in_valid & in_ready;
  assign w_n_full     = {in_data, r_n[7:0]};
  assign w_cnt_next   = r_word_cnt + 1'b1;
  assign w_last_word  = (32'(w_cnt_next) == 32'(r_n));
  assign w_too_big    = (32'(w_n_full) > MAX_WORDS);
  assign loaded_words = r_word_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_HDR0;
      r_n        <= '0;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_word     <= '0;
      imem_we    <= 1'b0;
      imem_wa    <= '0;
      imem_wd    <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        S_HDR0: begin
          if (w_xfer) begin
            r_n[7:0] <= in_data;
            r_state  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_xfer) begin
            r_n[15:8] <= in_data;
            if (w_n_full == 16'd0) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else if (w_too_big) begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            // Bytes enter at the top and shift down, so the first byte ends in bits 7:0.
            r_word     <= {in_data, r_word[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= S_WRITE;
              imem_we <= 1'b1;
              imem_wa <= r_word_cnt[ADDR_WIDTH-1:0];
              imem_wd <= {in_data, r_word};
            end
          end
        end
        S_WRITE: begin
          imem_we    <= 1'b0;
          r_word_cnt <= w_cnt_next;
          if (w_last_word) begin
            r_state   <= S_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DONE: begin
          imem_we <= 1'b0;
        end
        S_ERR: begin
          imem_we <= 1'b0;
        end
        default: begin
          r_state <= S_HDR0;
          imem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
